mem_bridge: RTL

//  Responder end of the core memory interface: accepts execute-stage requests (ifetch/rstrobe/wmask)
//  and runs them as byte transfers on an external 8-bit multiplexed address/data bus.
//  It returns idone/rdone/wdone and rdata to the core.

---
 rtl/mem_bridge_pkg.sv | 41 ++++
 rtl/mem_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the core-to-external-bus memory bridge.
package mem_bridge_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BUS_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADH,
        ADL,
        DATA0,
        DATA1,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FETCH,
        READ,
        WRITE
    } kind_t;

    // ext_ale bit order is {lo,hi}
    localparam logic [1:0] ALE_HI = 2'b01;
    localparam logic [1:0] ALE_LO = 2'b10;

    typedef struct packed {
        kind_t               kind;
        logic [ADDR_W-1:0]   baddr;
        logic [1:0]          lanes;
        logic [DATA_W-1:0]   wdata;
        logic                io;
    } req_t;

    // Only a lone high lane starts on the odd byte; everything else starts even.
    function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-2:0] a,
                                                    input logic [1:0]        lanes);
        return {a, (lanes == 2'b10)};
    endfunction

endpackage

// File: rtl/mem_bridge.sv
// Responder for core fetch/read/write requests, run as byte transfers on an
// 8-bit multiplexed address/data bus. One request in flight at a time.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned RV          = 16,
    parameter int unsigned VA          = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [VA-1:1] pc,
    input  logic          ifetch,
    input  logic [VA-1:1] addr,
    input  logic [1:0]    rstrobe,
    input  logic [1:0]    wmask,
    input  logic [RV-1:0] wdata,
    input  logic          io_access,
    output logic          idone,
    output logic          rdone,
    output logic          wdone,
    output logic [RV-1:0] rdata,
    output logic [7:0]    ext_ad_out,
    input  logic [7:0]    ext_ad_in,
    output logic          ext_ad_oe,
    output logic [1:0]    ext_ale,
    output logic          ext_rd,
    output logic          ext_wr,
    output logic          ext_io,
    input  logic          ext_ready
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state_q, state_d;
    req_t       req_q, req_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] lo_byte_q;
    logic       data_exit_c;
    logic       two_phase_c;

    logic       idone_d, rdone_d, wdone_d;
    logic [7:0] ad_out_d;
    logic       ad_oe_d, rd_d, wr_d, io_d;
    logic [1:0] ale_d;

    assign two_phase_c = (req_q.lanes == 2'b11);
    assign data_exit_c = ((state_q == DATA0) || (state_q == DATA1)) &&
                         (wait_q == 4'd0) && ext_ready;

    // Next state, request arbitration and wait counting
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (|wmask) begin
                    req_d.kind  = WRITE;
                    req_d.baddr = byte_addr(addr, wmask);
                    req_d.lanes = wmask;
                    req_d.wdata = wdata;
                    req_d.io    = io_access;
                    state_d     = ADH;
                end else if (|rstrobe) begin
                    req_d.kind  = READ;
                    req_d.baddr = byte_addr(addr, rstrobe);
                    req_d.lanes = rstrobe;
                    req_d.wdata = wdata;
                    req_d.io    = io_access;
                    state_d     = ADH;
                end else if (ifetch) begin
                    req_d.kind  = FETCH;
                    req_d.baddr = byte_addr(pc, 2'b11);
                    req_d.lanes = 2'b11;
                    req_d.wdata = wdata;
                    req_d.io    = 1'b0;
                    state_d     = ADH;
                end
            end
            ADH: state_d = ADL;
            ADL: begin
                state_d = DATA0;
                wait_d  = WAIT_INIT;
            end
            DATA0, DATA1: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (ext_ready) begin
                    state_d = (state_q == DATA0 && two_phase_c) ? DATA1 : DONE;
                    wait_d  = WAIT_INIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and done values for the state being entered, so outputs come straight off flops
    always_comb begin
        idone_d  = 1'b0;
        rdone_d  = 1'b0;
        wdone_d  = 1'b0;
        ad_out_d = 8'h00;
        ad_oe_d  = 1'b0;
        ale_d    = 2'b00;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        io_d     = 1'b0;
        case (state_d)
            ADH: begin
                ad_out_d = req_d.baddr[15:8];
                ale_d    = ALE_HI;
                ad_oe_d  = 1'b1;
                io_d     = req_d.io;
            end
            ADL: begin
                ad_out_d = req_d.baddr[7:0];
                ale_d    = ALE_LO;
                ad_oe_d  = 1'b1;
                io_d     = req_d.io;
            end
            DATA0, DATA1: begin
                io_d = req_d.io;
                if (req_d.kind == WRITE) begin
                    wr_d    = 1'b1;
                    ad_oe_d = 1'b1;
                    if (state_d == DATA1 || req_d.lanes == 2'b10) begin
                        ad_out_d = req_d.wdata[15:8];
                    end else begin
                        ad_out_d = req_d.wdata[7:0];
                    end
                end else begin
                    rd_d = 1'b1;
                end
            end
            DONE: begin
                io_d    = req_d.io;
                idone_d = (req_d.kind == FETCH);
                rdone_d = (req_d.kind == READ);
                wdone_d = (req_d.kind == WRITE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    // Read byte assembly; a single byte is replicated into both halves
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata     <= '0;
            lo_byte_q <= 8'h00;
        end else if (data_exit_c && req_q.kind != WRITE) begin
            if (state_q == DATA0 && two_phase_c) begin
                lo_byte_q <= ext_ad_in;
            end else if (state_q == DATA0) begin
                rdata <= {ext_ad_in, ext_ad_in};
            end else begin
                rdata <= {ext_ad_in, lo_byte_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idone      <= 1'b0;
            rdone      <= 1'b0;
            wdone      <= 1'b0;
            ext_ad_out <= 8'h00;
            ext_ad_oe  <= 1'b0;
            ext_ale    <= 2'b00;
            ext_rd     <= 1'b0;
            ext_wr     <= 1'b0;
            ext_io     <= 1'b0;
        end else begin
            idone      <= idone_d;
            rdone      <= rdone_d;
            wdone      <= wdone_d;
            ext_ad_out <= ad_out_d;
            ext_ad_oe  <= ad_oe_d;
            ext_ale    <= ale_d;
            ext_rd     <= rd_d;
            ext_wr     <= wr_d;
            ext_io     <= io_d;
        end
    end

endmodule
